// File: rtl/kgp_pkg.sv
// Kill/propagate/generate encodings and the prefix combine operator
// shared by the pipelined parallel-prefix adder.
package kgp_pkg;

   typedef logic [1:0] kgp_t;

   localparam kgp_t KGP_KILL = 2'b00;
   localparam kgp_t KGP_PROP = 2'b01;
   localparam kgp_t KGP_GEN  = 2'b11;

   // Upper group wins unless it merely propagates.
   function automatic kgp_t kgp_combine(
      input kgp_t upper,
      input kgp_t lower
   );
      return (upper == KGP_PROP) ? lower : upper;
   endfunction

   function automatic kgp_t kgp_encode(
      input logic a,
      input logic b
   );
      return {a & b, a | b};
   endfunction

endpackage

// File: rtl/prefix_cell.sv
// One Kogge-Stone node: merges an upper and a lower kgp group.
module prefix_cell
   import kgp_pkg::*;
(
   input  kgp_t upper_i,
   input  kgp_t lower_i,
   output kgp_t result_o
);

   assign result_o = kgp_combine(upper_i, lower_i);

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control
// and bubble-collapsing stages.
module prefix_adder_pipe
   import kgp_pkg::*;
#(
   parameter int WIDTH            = 32,
   parameter int LEVELS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int L   = $clog2(WIDTH);
   localparam int LPS = LEVELS_PER_STAGE;
   localparam int S   = (L + LPS - 1) / LPS;

   if (WIDTH < 4 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0
       || LPS < 1 || LPS > L) begin : g_bad_param
      $error("prefix_adder_pipe: illegal WIDTH/LEVELS_PER_STAGE");
   end

   typedef kgp_t [WIDTH-1:0] vec_t;

   vec_t             code_d [S+1];
   vec_t             code_q [S+1];
   logic [WIDTH-1:0] p_d;
   logic [WIDTH-1:0] p_q    [S+1];
   kgp_t             ci_d;
   kgp_t             ci_q   [S+1];
   logic [S:0]       valid_q;
   logic [S:0]       load;
   logic             tail_full;
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] carry;
   logic             carry_in;

   assign bx   = b ^ {WIDTH{sub}};
   assign p_d  = a ^ bx;
   assign ci_d = (sub | cin) ? KGP_GEN : KGP_KILL;

   for (genvar i = 0; i < WIDTH; i++) begin : g_enc
      assign code_d[0][i] = kgp_encode(a[i], bx[i]);
   end

   for (genvar s = 1; s <= S; s++) begin : g_stage
      for (genvar k = 0; k < LPS; k++) begin : g_lvl
         localparam int J = (s - 1) * LPS + k + 1;
         localparam int D = 1 << (J - 1);
         vec_t cur;
         vec_t nxt;
         if (k == 0) begin : g_first
            assign cur = code_q[s-1];
         end else begin : g_chain
            assign cur = g_lvl[k-1].nxt;
         end
         if (J <= L) begin : g_on
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
               kgp_t lo;
               // Low positions merge straight into the carry-in element.
               if (i >= D) begin : g_far
                  assign lo = cur[i-D];
               end else begin : g_cin
                  assign lo = ci_q[s-1];
               end
               prefix_cell u_cell (
                  .upper_i  (cur[i]),
                  .lower_i  (lo),
                  .result_o (nxt[i])
               );
            end
         end else begin : g_pass
            assign nxt = cur;
         end
      end
      assign code_d[s] = g_lvl[LPS-1].nxt;
   end

   // A stage loads if it, or any stage after it, has room.
   always_comb begin
      load      = '0;
      tail_full = 1'b1;
      for (int s = 0; s <= S; s++) begin
         tail_full = 1'b1;
         for (int t = s; t <= S; t++) begin
            tail_full = tail_full & valid_q[t];
         end
         load[s] = out_ready | ~tail_full;
      end
   end

   assign in_ready = load[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         if (load[0]) valid_q[0] <= in_valid;
         for (int s = 1; s <= S; s++) begin
            if (load[s]) valid_q[s] <= valid_q[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load[0] && in_valid) begin
         code_q[0] <= code_d[0];
         p_q[0]    <= p_d;
         ci_q[0]   <= ci_d;
      end
      for (int s = 1; s <= S; s++) begin
         if (load[s] && valid_q[s-1]) begin
            code_q[s] <= code_d[s];
            p_q[s]    <= p_q[s-1];
            ci_q[s]   <= ci_q[s-1];
         end
      end
   end

   always_comb begin
      carry = '0;
      for (int i = 0; i < WIDTH; i++) begin
         carry[i] = (code_q[S][i] == KGP_GEN);
      end
   end

   assign carry_in  = (ci_q[S] == KGP_GEN);
   assign out_valid = valid_q[S];

   always_comb begin
      sum  = '0;
      cout = 1'b0;
      ovf  = 1'b0;
      if (valid_q[S]) begin
         sum  = p_q[S] ^ {carry[WIDTH-2:0], carry_in};
         cout = carry[WIDTH-1];
         ovf  = carry[WIDTH-1] ^ carry[WIDTH-2];
      end
   end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and random checks of the pipelined prefix adder in its
// default 32-bit form and a 64-bit, two-levels-per-stage form.
module tb_prefix_adder_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, cin, sub;
   logic        out_valid, out_ready, cout, ovf;
   logic [31:0] a, b, sum;

   logic        w_in_valid, w_in_ready, w_cin, w_sub;
   logic        w_out_valid, w_out_ready, w_cout, w_ovf;
   logic [63:0] w_a, w_b, w_sum;

   int n_checks = 0;
   int n_fail   = 0;

   prefix_adder_pipe u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   prefix_adder_pipe #(
      .WIDTH            (64),
      .LEVELS_PER_STAGE (2)
   ) u_dut64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .a         (w_a),
      .b         (w_b),
      .cin       (w_cin),
      .sub       (w_sub),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .sum       (w_sum),
      .cout      (w_cout),
      .ovf       (w_ovf)
   );

   // Sends one operand set into an empty 32-bit pipe, waits for it.
   task automatic run_one(
      input  logic [31:0] ta,
      input  logic [31:0] tb_v,
      input  logic        tc,
      input  logic        ts,
      output logic [31:0] rs,
      output logic        rc,
      output logic        ro,
      output int          lat
   );
      a = ta; b = tb_v; cin = tc; sub = ts;
      in_valid = 1'b1; out_ready = 1'b1;
      lat = -1; rs = '0; rc = 1'b0; ro = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (out_valid) begin
            lat = n; rs = sum; rc = cout; ro = ovf;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] rs;
      logic        rc, ro;
      int          lat;
      rst_n = 1'b0;
      #12;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1",
                  out_valid, in_ready);
      end
      n_checks++;
      if ({sum, cout, ovf} !== 34'd0) begin
         n_fail++;
         $display("FAIL reset_out: sum=%h cout=%b ovf=%b want zeros",
                  sum, cout, ovf);
      end
      n_checks++;
      if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1
          || w_sum !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_w64: ov=%b ir=%b sum=%h want 0/1/0",
                  w_out_valid, w_in_ready, w_sum);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL first_ready: in_ready=%b want 1", in_ready);
      end
      run_one(32'd1, 32'd2, 1'b0, 1'b0, rs, rc, ro, lat);
      n_checks++;
      if (lat !== 6 || rs !== 32'd3) begin
         n_fail++;
         $display("FAIL first_accept: lat=%0d sum=%h want 6/3", lat, rs);
      end
   endtask

   task automatic test_arith();
      logic [31:0] va [9] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5,
                              32'd7, 32'd7, 32'd3, 32'h8000_0000,
                              32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] vb [9] = '{32'd1, 32'd1, 32'd7, 32'd5, 32'd5, 32'd4,
                              32'd1, 32'h8000_0000, 32'hFFFF_FFFF};
      logic        vc [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
      logic        vs [9] = '{0, 0, 1, 1, 1, 0, 1, 0, 0};
      logic [31:0] es [9] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFE,
                              32'd2, 32'd2, 32'd8, 32'h7FFF_FFFF,
                              32'h0, 32'hFFFF_FFFF};
      logic        ec [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
      logic        eo [9] = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
      logic [31:0] rs;
      logic        rc, ro;
      int          lat;
      for (int i = 0; i < 9; i++) begin
         run_one(va[i], vb[i], vc[i], vs[i], rs, rc, ro, lat);
         n_checks++;
         if (lat !== 6) begin
            n_fail++;
            $display("FAIL arith%0d latency: got %0d want 6", i, lat);
         end
         n_checks++;
         if (rs !== es[i]) begin
            n_fail++;
            $display("FAIL arith%0d sum: got %h want %h", i, rs, es[i]);
         end
         n_checks++;
         if (rc !== ec[i] || ro !== eo[i]) begin
            n_fail++;
            $display("FAIL arith%0d flags: cout=%b ovf=%b want %b %b",
                     i, rc, ro, ec[i], eo[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [8];
      logic [31:0] vb [8];
      logic [31:0] ex [8];
      int   acc = 0, got = 0, gaps = 0;
      logic fi;
      for (int i = 0; i < 8; i++) begin
         va[i] = 32'h1111_1111 * i + 32'h0F;
         vb[i] = i + 1;
         ex[i] = va[i] + vb[i];
      end
      cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (acc < 8);
         if (acc < 8) begin a = va[acc]; b = vb[acc]; end
         #1;
         fi = in_valid & in_ready;
         if (out_valid) begin
            n_checks++;
            if (sum !== ex[0]) begin
               n_fail++;
               $display("FAIL stall_hold: sum=%h want %h", sum, ex[0]);
            end
         end
         @(posedge clk); #1;
         if (fi) acc++;
      end
      n_checks++;
      if (acc !== 6) begin
         n_fail++;
         $display("FAIL stall_accept: accepted %0d want 6", acc);
      end
      a = va[acc]; b = vb[acc];
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_full: in_ready=%b out_valid=%b want 0/1",
                  in_ready, out_valid);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 30 && got < 8; c++) begin
         in_valid = (acc < 8);
         if (acc < 8) begin a = va[acc]; b = vb[acc]; end
         #1;
         fi = in_valid & in_ready;
         if (out_valid) begin
            n_checks++;
            if (sum !== ex[got]) begin
               n_fail++;
               $display("FAIL drain%0d: sum=%h want %h", got, sum, ex[got]);
            end
            got++;
         end else begin
            gaps++;
         end
         @(posedge clk); #1;
         if (fi) acc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (got !== 8 || gaps !== 0 || acc !== 8) begin
         n_fail++;
         $display("FAIL drain_count: got=%0d gaps=%0d acc=%0d want 8/0/8",
                  got, gaps, acc);
      end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'h100 * i; b = 32'd9; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: out_valid=%b want 1", out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 32'd0) begin
         n_fail++;
         $display("FAIL midrst_async: ov=%b ir=%b sum=%h want 0/1/0",
                  out_valid, in_ready, sum);
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midrst_stale: %0d results seen want 0", seen);
      end
   endtask

   task automatic test_wide64();
      logic [65:0] q [$];
      logic [65:0] exp_v;
      logic [64:0] full;
      logic [63:0] bb;
      logic        so, fi, fo;
      int          sent = 0, recv = 0, cyc = 0;
      w_in_valid = 1'b0;
      while (recv < 1000 && cyc < 20000) begin
         if (!w_in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
            w_a   = {$urandom(), $urandom()};
            w_b   = {$urandom(), $urandom()};
            w_cin = 1'($urandom_range(0, 1));
            w_sub = 1'($urandom_range(0, 1));
            if (sent == 0) begin
               w_a = '1; w_b = 64'd1; w_cin = 1'b0; w_sub = 1'b0;
            end
            if (sent == 1) begin
               w_a = 64'h7FFF_FFFF_FFFF_FFFF; w_b = 64'd1;
               w_cin = 1'b0; w_sub = 1'b0;
            end
            w_in_valid = 1'b1;
         end
         w_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         fi = w_in_valid & w_in_ready;
         fo = w_out_valid & w_out_ready;
         if (fi) begin
            bb   = w_sub ? ~w_b : w_b;
            full = {1'b0, w_a} + {1'b0, bb} + 65'(w_sub | w_cin);
            so   = (w_a[63] == bb[63]) && (full[63] != w_a[63]);
            q.push_back({full[64], so, full[63:0]});
         end
         if (fo) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL w64_extra: unexpected result %h", w_sum);
            end else begin
               exp_v = q.pop_front();
               if ({w_cout, w_ovf, w_sum} !== exp_v) begin
                  n_fail++;
                  $display("FAIL w64_%0d: got %b %b %h want %b %b %h",
                           recv, w_cout, w_ovf, w_sum,
                           exp_v[65], exp_v[64], exp_v[63:0]);
               end
            end
            recv++;
         end
         @(posedge clk); #1;
         cyc++;
         if (fi) begin
            sent++;
            w_in_valid = 1'b0;
         end
      end
      n_checks++;
      if (recv !== 1000 || q.size() != 0) begin
         n_fail++;
         $display("FAIL w64_total: recv=%0d left=%0d want 1000/0",
                  recv, q.size());
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      w_in_valid = 1'b0; w_out_ready = 1'b0;
      w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0;
      test_reset();
      test_arith();
      test_back_to_back();
      test_reset_midflight();
      test_wide64();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prefix_adder_pipe.md
PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width; it SHALL be a power of two from 4 to 128.
REQ-002 The block SHALL have parameter LEVELS_PER_STAGE, default 1, meaning prefix levels evaluated between consecutive pipeline registers; it SHALL be from 1 to log2(WIDTH).
REQ-003 The block SHALL have one clock, port clk, input, 1 bit.
REQ-004 The block SHALL have asynchronous active-low reset, port rst_n, input, 1 bit.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: stage 0 can accept.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in; it SHALL be ignored when sub=1.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 selects a+b+cin, 1 selects a-b.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-013 The block SHALL have port sum, output, WIDTH bits: result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of MSB; for sub, 1 means no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 Stage 0 SHALL register, per bit, the 2-bit kgp code from a and b' (b' = ~b when sub=1, else b), with KILL=00, PROP=01, GEN=11.
REQ-017 Stage 0 SHALL register a carry-in element of GEN when (sub=1 or cin=1), else KILL.
REQ-018 The block SHALL run a Kogge-Stone prefix of L=log2(WIDTH) levels.
  - At level j, position i SHALL combine with position i-2^(j-1).
  - Positions below 2^(j-1) SHALL combine with the carry-in element.
REQ-019 The prefix levels SHALL be split into S=ceil(L/LEVELS_PER_STAGE) registered stages.
REQ-020 Latency SHALL be LAT=S+1 cycles from input acceptance to out_valid when unstalled; the default configuration SHALL give 6 cycles.
REQ-021 The sum SHALL be computed as sum[i] = p[i] XOR carry[i-1], with carry[-1] the carry-in element.
  - cout SHALL be carry[WIDTH-1].
  - ovf SHALL be carry[WIDTH-1] XOR carry[WIDTH-2].
  - All three SHALL be valid with out_valid.
REQ-022 Each stage SHALL hold a valid bit, and a stage SHALL load when it is empty or its successor loads or drains (bubble-collapsing).
REQ-023 in_ready SHALL be asserted when stage 0 is empty or stage 0 advances in the same cycle.
REQ-024 A transfer SHALL occur only on in_valid AND in_ready at input, and on out_valid AND out_ready at output.
REQ-025 A simultaneous drain at the output and accept at the input in the same cycle SHALL sustain throughput of 1 result per cycle.
REQ-026 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL be held stable.
REQ-027 The pipeline SHALL hold at most S+1 results, and no accepted result SHALL be dropped, duplicated or reordered.
REQ-028 The adder SHALL use modulo-2^WIDTH arithmetic, with no saturation.

Reset
REQ-029 rst_n low SHALL asynchronously clear all stage valid bits, forcing out_valid=0 and in_ready=1.
REQ-030 Datapath registers SHALL not require reset, but sum, cout and ovf SHALL read 0 while out_valid=0 after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight results, and no stale result SHALL appear after release.
REQ-032 The first acceptance SHALL be possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-033 Shared package kgp_pkg SHALL hold the KILL/PROP/GEN encodings and a function for the kgp combine operator.
REQ-034 One sub-module, prefix_cell, SHALL implement the 2-bit combine (upper, lower) -> result, with upper taking precedence unless it is PROP.
REQ-035 Stage count and level-to-stage mapping SHALL be localparams derived from WIDTH and LEVELS_PER_STAGE.

Verification
REQ-036 Default parameters, a=0xFFFFFFFF, b=1, sub=0, cin=0 -> after 6 cycles sum=0x00000000, cout=1, ovf=0.
REQ-037 a=0x7FFFFFFF, b=1, sub=0, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-038 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-039 out_ready=0 while 8 back-to-back inputs are offered -> exactly 6 are accepted, then in_ready=0.
  - Raising out_ready -> all 8 results emerge in order, 1 per cycle.
REQ-040 rst_n pulsed low with 3 results in flight -> out_valid falls immediately and no result appears afterwards.
REQ-041 WIDTH=64, LEVELS_PER_STAGE=2 (S=3, LAT=4) with 1000 random vectors and random out_ready -> all results match the golden model, with no loss.
